// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational RAW hazard check between the ID instruction and older EXE/MEM instructions.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src_1,
  input  logic [REG_W-1:0] src_2,
  input  logic             two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             forward_en,
  output logic             hazard
);

  logic exe_match, mem_match;

  always_comb begin
    exe_match = (src_1 == exe_dest) || (two_src && (src_2 == exe_dest));
    mem_match = (src_1 == mem_dest) || (two_src && (src_2 == mem_dest));
    // With forwarding only a load in EXE cannot be bypassed in time.
    if (forward_en)
      hazard = exe_match && exe_mem_r_en;
    else
      hazard = (exe_match && exe_wb_en) || (mem_match && mem_wb_en);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush arbiter for the five-stage pipeline: SRAM wait FSM, branch flush, hazard stall, perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src_1,
  input  logic [REG_W-1:0] src_2,
  input  logic             two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             forward_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_done,
  output logic             mem_go,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             id_exe_freeze,
  output logic             exe_mem_freeze,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state;
  logic [TMO_W-1:0] wait_cnt;
  logic             hazard, mem_stall, br_flush, haz_stall;

  hazard_detect u_hazard (
    .src_1        (src_1),
    .src_2        (src_2),
    .two_src      (two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .forward_en   (forward_en),
    .hazard       (hazard)
  );

  // Outputs are forced low while reset is held so nothing leaks out mid-reset.
  always_comb begin
    mem_go    = rst && (state == RUN) && mem_req;
    mem_stall = rst && (mem_go || ((state == WAIT) && !mem_done) || (state == ERR));
    br_flush  = rst && !mem_stall && branch_taken;
    haz_stall = rst && !mem_stall && !branch_taken && hazard;
  end

  assign pc_freeze      = mem_stall | haz_stall;
  assign if_id_freeze   = mem_stall | haz_stall;
  assign id_exe_freeze  = mem_stall;
  assign exe_mem_freeze = mem_stall;
  assign mem_wb_flush   = mem_stall;
  assign if_id_flush    = br_flush;
  assign id_exe_flush   = br_flush | haz_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_done) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == TMO_LAST) begin
              state   <= ERR;
              mem_err <= 1'b1;
            end
          end
        end
        ERR: begin
          state   <= ERR;
          mem_err <= 1'b1;
        end
        default: state <= RUN;
      endcase

      if (pc_freeze && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (br_flush && (flush_cnt != '1))  flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for hazard/branch arbitration plus SRAM wait sequences.
module tb_pipeline_ctrl;

  localparam int CNT_W = 8;
  localparam int TMO_W = 8;
  localparam int MEM_TIMEOUT = 200;

  logic clk, rst;
  logic [3:0] src_1, src_2, exe_dest, mem_dest;
  logic two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, forward_en, branch_taken, mem_req, mem_done;
  logic mem_go, pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze;
  logic if_id_flush, id_exe_flush, mem_wb_flush, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.CNT_W(CNT_W), .TMO_W(TMO_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .src_1(src_1), .src_2(src_2), .two_src(two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .forward_en(forward_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_done(mem_done),
    .mem_go(mem_go), .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze),
    .id_exe_freeze(id_exe_freeze), .exe_mem_freeze(exe_mem_freeze),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush), .mem_wb_flush(mem_wb_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_go, pc_frz, if_id_frz, id_exe_frz, exe_mem_frz, if_id_fl, id_exe_fl, mem_wb_fl}
  logic [7:0] outs;
  assign outs = {mem_go, pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze,
                 if_id_flush, id_exe_flush, mem_wb_flush};

  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_HAZ  = 8'b0110_0010;
  localparam logic [7:0] O_BR   = 8'b0000_0110;
  localparam logic [7:0] O_GO   = 8'b1111_1001;
  localparam logic [7:0] O_WAIT = 8'b0111_1001;

  typedef struct {
    string      name;
    logic [3:0] s1, s2;
    logic       two;
    logic [3:0] ed;
    logic       ewb, emr;
    logic [3:0] md;
    logic       mwb, fwd, br;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    src_1 = 0; src_2 = 0; two_src = 0; exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0; forward_en = 0; branch_taken = 0; mem_req = 0; mem_done = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic add(input string n, input logic [3:0] s1, input logic [3:0] s2, input logic two,
                     input logic [3:0] ed, input logic ewb, input logic emr, input logic [3:0] md,
                     input logic mwb, input logic fwd, input logic br, input logic [7:0] exp);
    vec_t v;
    v.name = n; v.s1 = s1; v.s2 = s2; v.two = two; v.ed = ed; v.ewb = ewb; v.emr = emr;
    v.md = md; v.mwb = mwb; v.fwd = fwd; v.br = br; v.exp = exp;
    vecs.push_back(v);
  endtask

  int exp_stall, exp_flush;

  initial begin
    //   name          s1 s2 two ed ewb emr md mwb fwd br  exp
    add("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
    add("load_use",     3, 0, 0, 3, 0, 1, 0, 0, 1, 0, O_HAZ);
    add("load_use_br",  3, 0, 0, 3, 0, 1, 0, 0, 1, 1, O_BR);
    add("fwd_alu_ok",   3, 0, 0, 3, 1, 0, 0, 0, 1, 0, O_IDLE);
    add("nofwd_mem_s2", 0, 7, 1, 0, 0, 0, 7, 1, 0, 0, O_HAZ);
    add("nofwd_no_s2",  0, 7, 0, 0, 0, 0, 7, 1, 0, 0, O_IDLE);
    add("nofwd_exe",    5, 0, 0, 5, 1, 0, 0, 0, 0, 0, O_HAZ);
    add("nofwd_exe_nw", 5, 0, 0, 5, 0, 0, 0, 0, 0, 0, O_IDLE);
    add("load_use_s2",  1, 9, 1, 9, 0, 1, 0, 0, 1, 0, O_HAZ);
    add("load_no_s2",   1, 9, 0, 9, 0, 1, 0, 0, 1, 0, O_IDLE);
    add("branch_only",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BR);

    idle();
    rst = 1'b0;
    #12;
    chk("reset_outs", outs, O_IDLE);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    chk("reset_mem_err", mem_err, 0);
    rst = 1'b1;
    step();
    chk("idle_outs", outs, O_IDLE);

    exp_stall = 0;
    exp_flush = 0;
    foreach (vecs[i]) begin
      src_1 = vecs[i].s1; src_2 = vecs[i].s2; two_src = vecs[i].two;
      exe_dest = vecs[i].ed; exe_wb_en = vecs[i].ewb; exe_mem_r_en = vecs[i].emr;
      mem_dest = vecs[i].md; mem_wb_en = vecs[i].mwb; forward_en = vecs[i].fwd;
      branch_taken = vecs[i].br;
      #3;
      chk(vecs[i].name, outs, vecs[i].exp);
      exp_stall += int'(vecs[i].exp[6]);
      exp_flush += int'(vecs[i].exp[2]);
      step();
    end
    idle();
    chk("table_stall_cnt", stall_cnt, exp_stall);
    chk("table_flush_cnt", flush_cnt, exp_flush);

    // SRAM access of go + 4 waits + exit, with a branch parked in EXE throughout
    do_reset();
    mem_req = 1; branch_taken = 1; mem_done = 1;
    #3; chk("go_cycle", outs, O_GO);
    step();
    mem_done = 0;
    for (int i = 0; i < 4; i++) begin
      #3; chk($sformatf("wait_%0d", i), outs, O_WAIT);
      step();
    end
    mem_done = 1; mem_req = 0;
    #3; chk("exit_branch", outs, O_BR);
    step();
    idle();
    chk("mem_stall_cnt", stall_cnt, 5);
    chk("mem_flush_cnt", flush_cnt, 1);
    mem_done = 1;
    #3; chk("done_in_run", outs, O_IDLE);
    step();
    mem_done = 0;
    #3; chk("after_done_in_run", outs, O_IDLE);

    // back-to-back request, then a second access that times out
    do_reset();
    mem_req = 1;
    #3; chk("b2b_go1", outs, O_GO);
    step();
    #3; chk("b2b_wait", outs, O_WAIT);
    step();
    mem_done = 1;
    #3; chk("b2b_exit", outs, O_IDLE);
    step();
    mem_done = 0;
    #3; chk("b2b_go2", outs, O_GO);
    step();
    mem_req = 0;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step();
    chk("tmo_err_early", mem_err, 0);
    chk("tmo_outs_early", outs, O_WAIT);
    step();
    chk("tmo_err_set", mem_err, 1);
    chk("tmo_stall_cnt", stall_cnt, 3 + MEM_TIMEOUT);
    mem_req = 1; mem_done = 1; branch_taken = 1;
    #3; chk("err_outs", outs, O_WAIT);
    for (int i = 0; i < 60; i++) step();
    chk("err_sticky", mem_err, 1);
    chk("stall_cnt_sat", stall_cnt, 255);
    chk("err_outs_late", outs, O_WAIT);
    rst = 1'b0;
    #1;
    chk("rst_outs", outs, O_IDLE);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst = 1'b1;
    idle();

    // reset asserted mid-WAIT returns to RUN
    step();
    mem_req = 1;
    step();
    mem_req = 0;
    step();
    #1; chk("midwait_pre", outs, O_WAIT);
    rst = 1'b0; mem_req = 1;
    #1; chk("midwait_rst_outs", outs, O_IDLE);
    rst = 1'b1; mem_req = 0;
    #1; chk("midwait_run", outs, O_IDLE);
    step();
    chk("midwait_run_next", outs, O_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage ARM pipeline. It drives the freeze and flush inputs of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It arbitrates three event sources: a multi-cycle SRAM access in MEM, a taken branch in EXE, and a data hazard between the instruction in ID and older instructions. It also runs a request/done handshake with the SRAM controller, a timeout watchdog, and two saturating performance counters.

## Interface
Parameters:
- CNT_W, 16, width of performance counters
- TMO_W, 8, width of memory wait counter
- MEM_TIMEOUT, 200, wait cycles before error (must be < 2^TMO_W)

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-low
- src_1  in  4  Rn of instruction in ID
- src_2  in  4  Rm/Rd source of instruction in ID
- two_src  in  1  ID instruction reads src_2
- exe_dest  in  4  destination register of the instruction in EXE
- exe_wb_en  in  1  EXE instruction writes back
- exe_mem_r_en  in  1  EXE instruction is a load
- mem_dest  in  4  destination register of the instruction in MEM
- mem_wb_en  in  1  MEM instruction writes back
- forward_en  in  1  forwarding unit active
- branch_taken  in  1  taken branch resolved in EXE
- mem_req  in  1  MEM instruction needs an SRAM access
- mem_done  in  1  SRAM access complete (1-cycle pulse)
- mem_go  out  1  start SRAM access (1-cycle pulse)
- pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze  out  1 each  hold the corresponding register
- if_id_flush, id_exe_flush, mem_wb_flush  out  1 each  load a bubble into the corresponding register
- mem_err  out  1  sticky SRAM timeout flag
- stall_cnt  out  CNT_W  cycles with pc_freeze high, saturating
- flush_cnt  out  CNT_W  branch flushes, saturating

## Operation
- FSM states: RUN, WAIT, ERR. Reset state is RUN.
- RUN with mem_req:
  - Assert mem_go.
  - Assert mem_stall, meaning pc/if_id/id_exe/exe_mem freeze plus mem_wb_flush.
  - Clear the wait counter and go to WAIT.
- WAIT with no mem_done:
  - Assert mem_stall and increment the wait counter.
  - If the counter equals MEM_TIMEOUT, go to ERR.
- WAIT with mem_done:
  - No mem_stall; the pipeline advances and MEM/WB captures the data.
  - Return to RUN. Hazard and branch logic apply normally in this cycle.
- ERR: mem_stall held permanently and mem_err=1 until reset. mem_go is never reasserted.
- Hazard logic (used when there is no mem_stall):
  - A match means src_1==D, or two_src & src_2==D.
  - With forward_en=1: a hazard is a match against exe_dest with exe_mem_r_en=1 (load-use).
  - With forward_en=0: a hazard is a match against exe_dest with exe_wb_en=1, or against mem_dest with mem_wb_en=1.
  - On a hazard: pc_freeze=1, if_id_freeze=1, id_exe_flush=1.
- Branch logic (used when there is no mem_stall): branch_taken gives if_id_flush=1 and id_exe_flush=1, and no freezes. Branch overrides any hazard in the same cycle.
- Priority: mem_stall > branch > hazard.
  - During mem_stall, if_id_flush and id_exe_flush are 0.
  - A branch held in EXE is flushed on the WAIT→RUN exit cycle.
- Counters:
  - stall_cnt increments in every cycle with pc_freeze=1.
  - flush_cnt increments in every cycle with branch flush applied.
  - Both saturate at all-ones.

## Timing
- All freeze/flush outputs and mem_go are combinational from the current state and inputs, and are valid in the same cycle.
- state, the wait counter, mem_err, stall_cnt and flush_cnt are registered.
- Reset values: state=RUN, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- With inputs idle, every freeze/flush output and mem_go is 0.
- Minimum SRAM access is 2 cycles: the go cycle plus the done cycle. mem_done in the go cycle is ignored.
- A back-to-back mem_req in the exit cycle is a new instruction; the next RUN cycle issues mem_go again.
- Reset mid-WAIT returns to RUN at once and drops all outputs. The SRAM controller is reset by the same rst.
- mem_done while in RUN or ERR is ignored.

## Structure
- The shared package holds the FSM state localparams (RUN=2'd0, WAIT=2'd1, ERR=2'd2) and the register-index width 4.
- Sub-module hazard_detect is purely combinational: src/dest/enable inputs in, hazard bit out. Instantiate it once.
- The FSM, counters and output priority mux live in pipeline_ctrl.

## Test plan
- Reset release, all inputs 0 → all outputs 0, both counters 0.
- forward_en=1, exe_mem_r_en=1, exe_dest=3, src_1=3 for one cycle → pc_freeze, if_id_freeze, id_exe_flush=1 for that cycle; stall_cnt=1 afterwards.
- Same as above plus branch_taken=1 → if_id_flush=id_exe_flush=1, pc_freeze=0, flush_cnt=1.
- mem_req=1 with mem_done after 4 WAIT cycles, branch_taken=1 throughout:
  - mem_go pulses once in the first cycle.
  - Freezes and mem_wb_flush are high for 5 cycles, with no flushes.
  - The exit cycle shows the branch flush.
  - stall_cnt=5.
- mem_req=1 and mem_done never asserted → mem_err rises after MEM_TIMEOUT WAIT cycles and stays high; freezes remain; rst low clears everything.
- forward_en=0, mem_wb_en=1, mem_dest=7, two_src=1, src_2=7 → hazard asserted; with two_src=0 → no hazard.
